// File: rtl/sub_issue_collect.sv
// Issue/collect shell around a fixed-latency unsigned subtractor core.
// Tags ride alongside the core pipeline; results land in a credit-protected FIFO.
module sub_issue_collect #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             sub_ce,
  output logic [WIDTH-1:0] sub_a,
  output logic [WIDTH-1:0] sub_b,
  input  logic [WIDTH-1:0] sub_s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow,
  output logic             busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = $clog2(LATENCY + 1);
  localparam int UW = ((CW > LW) ? CW : LW) + 1;

  logic [LATENCY-1:0] tag_v;
  logic [LATENCY-1:0] tag_brw;
  logic [LATENCY-1:0] tag_v_nx;
  logic [LATENCY-1:0] tag_brw_nx;

  logic [WIDTH:0]     mem [DEPTH];
  logic [AW-1:0]      wptr;
  logic [AW-1:0]      rptr;
  logic [CW-1:0]      count;

  logic [LW-1:0]      inflight;
  logic [UW-1:0]      used;
  logic               fire;
  logic               push;
  logic               pop;
  logic [WIDTH:0]     head;

  assign sub_a = in_a;
  assign sub_b = in_b;

  // Credit check uses registered state only; a pop frees credit next cycle.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++)
      inflight = inflight + LW'(tag_v[i]);
    used     = UW'(count) + UW'(inflight);
    in_ready = used < UW'(DEPTH);
  end

  assign fire      = in_valid & in_ready;
  assign sub_ce    = fire | (|tag_v);
  assign push      = sub_ce & tag_v[LATENCY-1];
  assign out_valid = count != '0;
  assign pop       = out_valid & out_ready;
  assign busy      = (|tag_v) | out_valid;

  assign head       = mem[rptr];
  assign out_diff   = out_valid ? head[WIDTH:1] : '0;
  assign out_borrow = out_valid & head[0];

  // Next tag stage contents: new op enters stage 0, others move up.
  always_comb begin
    tag_v_nx      = '0;
    tag_brw_nx    = '0;
    tag_v_nx[0]   = fire;
    tag_brw_nx[0] = in_a < in_b;
    for (int i = 1; i < LATENCY; i++) begin
      tag_v_nx[i]   = tag_v[i-1];
      tag_brw_nx[i] = tag_brw[i-1];
    end
  end

  // Tag pipeline advances in lockstep with the core's enable.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tag_v   <= '0;
      tag_brw <= '0;
    end else if (sub_ce) begin
      tag_v   <= tag_v_nx;
      tag_brw <= tag_brw_nx;
    end
  end

  // Result storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= {sub_s, tag_brw[LATENCY-1]};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)
        wptr <= wptr + AW'(1);
      if (pop)
        rptr <= rptr + AW'(1);
      unique case (1'b1)
        push & ~pop: count <= count + CW'(1);
        pop & ~push: count <= count - CW'(1);
        default:     count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_issue_collect.sv
// Directed and randomized bench for sub_issue_collect.
// Includes a behavioural model of the enable-gated subtractor core.
module tb_sub_issue_collect;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        sub_ce;
  logic [15:0] sub_a;
  logic [15:0] sub_b;
  logic [15:0] sub_s;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_diff;
  logic        out_borrow;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int nfire = 0;
  int npop  = 0;
  int acc;
  int guard;
  logic [16:0] q[$];

  sub_issue_collect #(.WIDTH(16), .LATENCY(2), .DEPTH(4)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .sub_ce(sub_ce), .sub_a(sub_a), .sub_b(sub_b), .sub_s(sub_s),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_diff(out_diff), .out_borrow(out_borrow),
    .busy(busy)
  );

  logic [15:0] pipe0;
  logic [15:0] pipe1;

  always @(posedge clk) begin
    if (sub_ce) begin
      pipe0 <= sub_a - sub_b;
      pipe1 <= pipe0;
    end
  end
  assign sub_s = pipe1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    logic [16:0] e;
    #1;
    if (in_valid && in_ready) begin
      q.push_back({in_a - in_b, in_a < in_b});
      nfire++;
    end
    if (out_valid && out_ready) begin
      npop++;
      total++;
      assert (q.size() > 0) else begin
        bad++;
        $error("FAIL pop_unexpected obs=%0h exp=none", out_diff);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pop_data", {15'd0, out_diff, out_borrow}, {15'd0, e});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string tag, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] ed,
                         input logic eb);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    chk({tag, "_rdy"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    #1 chk({tag, "_ov1"}, out_valid, 0);
    tick();
    #1 chk({tag, "_ov2"}, out_valid, 0);
    tick();
    #1;
    chk({tag, "_ov3"}, out_valid, 1);
    chk({tag, "_diff"}, out_diff, ed);
    chk({tag, "_brw"}, out_borrow, eb);
    tick();
  endtask

  initial begin
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ov", out_valid, 0);
    chk("rst_ce", sub_ce, 0);
    chk("rst_busy", busy, 0);
    chk("rst_diff", out_diff, 0);
    chk("rst_brw", out_borrow, 0);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_rdy", in_ready, 1);

    // single op 5-3 with latency and busy checks
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 16'd5;
    in_b      = 16'd3;
    tick();
    in_valid = 1'b0;
    #1;
    chk("t1_ov1", out_valid, 0);
    chk("t1_ce1", sub_ce, 1);
    tick();
    #1 chk("t1_ov2", out_valid, 0);
    tick();
    #1;
    chk("t1_ov3", out_valid, 1);
    chk("t1_diff", out_diff, 16'h0002);
    chk("t1_brw", out_borrow, 0);
    tick();
    #1;
    chk("t1_busy4", busy, 0);
    chk("t1_ce4", sub_ce, 0);
    chk("t1_ov4", out_valid, 0);

    // borrow and edge operands
    run_one("t2a", 16'd3, 16'd5, 16'hFFFE, 1'b1);
    run_one("t2b", 16'd0, 16'd0, 16'h0000, 1'b0);
    run_one("t2c", 16'hFFFF, 16'd0, 16'hFFFF, 1'b0);

    // back-to-back with a stalled consumer
    out_ready = 1'b0;
    in_valid  = 1'b1;
    acc       = 0;
    for (int c = 0; c < 8; c++) begin
      in_a = 16'(acc + 10);
      in_b = 16'(acc);
      #1;
      if (in_ready) acc++;
      tick();
    end
    chk("t3_acc", acc, 4);
    #1;
    chk("t3_rdy", in_ready, 0);
    chk("t3_ce", sub_ce, 0);
    out_ready = 1'b1;
    npop      = 0;
    guard     = 0;
    while ((acc < 8 || q.size() > 0) && guard < 100) begin
      if (acc < 8) begin
        in_valid = 1'b1;
        in_a     = 16'(acc + 10);
        in_b     = 16'(acc);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && in_ready) acc++;
      tick();
      guard++;
    end
    in_valid = 1'b0;
    chk("t3_timeout", guard < 100, 1);
    chk("t3_npop", npop, 8);
    chk("t3_qempty", q.size(), 0);

    // full FIFO, single pop frees credit next cycle
    out_ready = 1'b0;
    in_valid  = 1'b1;
    acc       = 0;
    guard     = 0;
    while (acc < 4 && guard < 20) begin
      in_a = 16'(100 + acc);
      in_b = 16'(acc * 3);
      #1;
      if (in_ready) acc++;
      tick();
      guard++;
    end
    in_valid = 1'b0;
    repeat (4) tick();
    #1;
    chk("t4_full_rdy", in_ready, 0);
    chk("t4_full_ov", out_valid, 1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 16'd200;
    in_b      = 16'd1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    #1 chk("t4_rdy_after", in_ready, 1);

    // random traffic against the queue model
    nfire = 0;
    guard = 0;
    while (nfire < 1000 && guard < 20000) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = 16'($urandom);
      in_b      = ($urandom_range(0, 7) == 0) ? in_a : 16'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      tick();
      guard++;
    end
    chk("t4_rand_timeout", nfire >= 1000, 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard     = 0;
    while (q.size() > 0 && guard < 50) begin
      tick();
      guard++;
    end
    chk("t4_drain", q.size(), 0);
    #1 chk("t4_idle", busy, 0);

    // reset with two ops in flight
    in_valid = 1'b1;
    in_a     = 16'd50;
    in_b     = 16'd1;
    tick();
    in_a = 16'd60;
    in_b = 16'd2;
    tick();
    in_valid = 1'b0;
    resetn   = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    #1 chk("t5_busy", busy, 0);
    for (int c = 0; c < 5; c++) begin
      #1 chk("t5_no_ov", out_valid, 0);
      tick();
    end
    run_one("t5", 16'd9, 16'd4, 16'd5, 1'b0);

    // ce holds only while an op drains
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 16'd7;
    in_b      = 16'd2;
    tick();
    in_valid = 1'b0;
    #1 chk("t6_ce1", sub_ce, 1);
    tick();
    #1 chk("t6_ce2", sub_ce, 1);
    tick();
    #1;
    chk("t6_ce3", sub_ce, 0);
    chk("t6_ov3", out_valid, 1);
    chk("t6_diff", out_diff, 16'd5);
    tick();
    #1 chk("t6_ce4", sub_ce, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
